// File: rtl/ecg_window_buffer_if.sv
// ECG window buffer bus: sample stream in, window read port out.
// master drives start/in_valid/in_data/rd_addr/win_done; slave is the buffer.
interface ecg_window_buffer_if #(
  parameter int DATA_W  = 8,
  parameter int WIN_LEN = 16
);
  localparam int AW = $clog2(WIN_LEN);

  logic              start;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              win_valid;
  logic              win_bank;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] win_max;
  logic              win_done;
  logic [15:0]       win_count;
  logic              busy;

  modport master (
    output start, in_valid, in_data, rd_addr, win_done,
    input  in_ready, win_valid, win_bank, rd_data,
    input  win_max, win_count, busy
  );

  modport slave (
    input  start, in_valid, in_data, rd_addr, win_done,
    output in_ready, win_valid, win_bank, rd_data,
    output win_max, win_count, busy
  );
endinterface

// File: rtl/ecg_window_buffer.sv
// Ping-pong ECG sample window framer with peak tracking.
// Ports: clk, rst (async active-low), bus (slave: stream + window read).
module ecg_window_buffer #(
  parameter int DATA_W     = 8,
  parameter int WIN_LEN    = 16,
  parameter bit CONTINUOUS = 1'b0
) (
  input logic               clk,
  input logic               rst,
  ecg_window_buffer_if.slave bus
);

  localparam int AW = $clog2(WIN_LEN);
  localparam logic [AW:0] LIM = (AW+1)'(WIN_LEN);
  localparam logic [AW-1:0] LAST = AW'(WIN_LEN - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]        state;
  logic              wb;
  logic              rb;
  logic              rb_n;
  logic [1:0]        full;
  logic [1:0]        full_n;
  logic [AW-1:0]     wr_ptr;
  logic [DATA_W-1:0] run_max;
  logic [DATA_W-1:0] cur_max;
  logic [DATA_W-1:0] bank_max [2];
  logic [DATA_W-1:0] mem [2][WIN_LEN];
  logic [15:0]       cnt;
  logic [DATA_W-1:0] rd_q;
  logic [DATA_W-1:0] rd_sel;
  logic              accept;
  logic              last;
  logic              free_rd;
  logic              other_free;

  assign accept  = (state == S_FILL) && bus.in_valid;
  assign last    = accept && (wr_ptr == LAST);
  assign free_rd = bus.win_done && (|full);

  // Other bank is usable now, counting a release in this same cycle.
  assign other_free = !full[~wb] || (free_rd && (rb == ~wb));

  assign cur_max = ((wr_ptr == '0) || (bus.in_data > run_max))
                 ? bus.in_data : run_max;

  assign rd_sel = ({1'b0, bus.rd_addr} < LIM)
                ? mem[rb][bus.rd_addr] : '0;

  always_comb begin
    full_n = full;
    if (free_rd) full_n[rb] = 1'b0;
    if (last)    full_n[wb] = 1'b1;
  end

  // Presented bank is the oldest full one; a completion with the
  // other bank empty becomes the presented bank directly.
  always_comb begin
    rb_n = rb;
    if (free_rd) rb_n = ~rb;
    if (last && !full_n[~wb]) rb_n = wb;
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wb][wr_ptr] <= bus.in_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      wb          <= 1'b0;
      rb          <= 1'b0;
      full        <= 2'b00;
      wr_ptr      <= '0;
      run_max     <= '0;
      bank_max[0] <= '0;
      bank_max[1] <= '0;
      cnt         <= '0;
      rd_q        <= '0;
    end else begin
      full <= full_n;
      rb   <= rb_n;
      if (|full) rd_q <= rd_sel;
      if (accept) begin
        wr_ptr  <= wr_ptr + 1'b1;
        run_max <= cur_max;
      end
      if (last) begin
        bank_max[wb] <= cur_max;
        cnt          <= cnt + 16'd1;
        wr_ptr       <= '0;
      end
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            wr_ptr <= '0;
            if (!full[wb]) begin
              state <= S_FILL;
            end else if (!full[~wb]) begin
              wb    <= ~wb;
              state <= S_FILL;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_FILL: begin
          if (last) begin
            if (!CONTINUOUS) state <= S_IDLE;
            else if (other_free) wb <= ~wb;
            else state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!full[~wb]) begin
            wb    <= ~wb;
            state <= S_FILL;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_FILL);
  assign bus.win_valid = |full;
  assign bus.win_bank  = rb;
  assign bus.rd_data   = rd_q;
  assign bus.win_max   = bank_max[rb];
  assign bus.win_count = cnt;
  assign bus.busy      = (state != S_IDLE) || (|full);

endmodule

// File: tb/tb_ecg_window_buffer.sv
// Bench: single-shot and continuous buffers against a window-queue model.
// Directed scenarios followed by randomized traffic.
module tb_ecg_window_buffer;

  localparam int DW = 8;
  localparam int WL = 16;
  localparam int AW = 4;
  localparam int M_IDLE = 0;
  localparam int M_FILL = 1;
  localparam int M_WAIT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ecg_window_buffer_if #(.DATA_W(DW), .WIN_LEN(WL)) b0 ();
  ecg_window_buffer_if #(.DATA_W(DW), .WIN_LEN(WL)) b1 ();

  ecg_window_buffer #(
    .DATA_W(DW), .WIN_LEN(WL), .CONTINUOUS(1'b0)
  ) u_ss (.clk(clk), .rst(rst), .bus(b0));

  ecg_window_buffer #(
    .DATA_W(DW), .WIN_LEN(WL), .CONTINUOUS(1'b1)
  ) u_ct (.clk(clk), .rst(rst), .bus(b1));

  logic          s_start [2];
  logic          s_valid [2];
  logic          s_done  [2];
  logic [DW-1:0] s_data  [2];
  logic [AW-1:0] s_addr  [2];

  assign b0.start    = s_start[0];
  assign b0.in_valid = s_valid[0];
  assign b0.in_data  = s_data[0];
  assign b0.rd_addr  = s_addr[0];
  assign b0.win_done = s_done[0];
  assign b1.start    = s_start[1];
  assign b1.in_valid = s_valid[1];
  assign b1.in_data  = s_data[1];
  assign b1.rd_addr  = s_addr[1];
  assign b1.win_done = s_done[1];

  logic          o_rdy  [2];
  logic          o_wv   [2];
  logic          o_bank [2];
  logic          o_busy [2];
  logic [DW-1:0] o_rd   [2];
  logic [DW-1:0] o_max  [2];
  logic [15:0]   o_cnt  [2];

  assign o_rdy[0]  = b0.in_ready;
  assign o_wv[0]   = b0.win_valid;
  assign o_bank[0] = b0.win_bank;
  assign o_busy[0] = b0.busy;
  assign o_rd[0]   = b0.rd_data;
  assign o_max[0]  = b0.win_max;
  assign o_cnt[0]  = b0.win_count;
  assign o_rdy[1]  = b1.in_ready;
  assign o_wv[1]   = b1.win_valid;
  assign o_bank[1] = b1.win_bank;
  assign o_busy[1] = b1.busy;
  assign o_rd[1]   = b1.rd_data;
  assign o_max[1]  = b1.win_max;
  assign o_cnt[1]  = b1.win_count;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Model: capture mode, the sample being filled, and the list of
  // completed windows in the order the reader must see them.
  int            m_st  [2];
  bit            m_wb  [2];
  int            m_ptr [2];
  logic [DW-1:0] m_run [2];
  logic [DW-1:0] m_mem [2][2][WL];
  logic [DW-1:0] m_mx  [2][2];
  int            m_n   [2];
  bit            m_ord [2][2];
  int unsigned   m_cnt [2];
  logic [DW-1:0] m_rd  [2];

  function automatic bit mfull(input int k, input bit b);
    return (m_n[k] > 0 && m_ord[k][0] == b) ||
           (m_n[k] > 1 && m_ord[k][1] == b);
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k]  = M_IDLE;
      m_wb[k]  = 1'b0;
      m_ptr[k] = 0;
      m_run[k] = '0;
      m_n[k]   = 0;
      m_cnt[k] = 0;
      m_rd[k]  = '0;
    end
  endtask

  task automatic m_step(input int k);
    bit f_wb;
    bit f_ow;
    bit cont;
    cont = (k == 1);
    f_wb = mfull(k, m_wb[k]);
    f_ow = mfull(k, !m_wb[k]);
    if (m_n[k] > 0)
      m_rd[k] = m_mem[k][m_ord[k][0]][s_addr[k]];
    if (s_done[k] && m_n[k] > 0) begin
      m_ord[k][0] = m_ord[k][1];
      m_n[k]--;
    end
    case (m_st[k])
      M_IDLE: if (s_start[k]) begin
        m_ptr[k] = 0;
        if (!f_wb) m_st[k] = M_FILL;
        else if (!f_ow) begin
          m_wb[k] = !m_wb[k];
          m_st[k] = M_FILL;
        end else m_st[k] = M_WAIT;
      end
      M_FILL: if (s_valid[k]) begin
        m_mem[k][m_wb[k]][m_ptr[k]] = s_data[k];
        if (m_ptr[k] == 0 || s_data[k] > m_run[k])
          m_run[k] = s_data[k];
        m_ptr[k]++;
        if (m_ptr[k] == WL) begin
          m_mx[k][m_wb[k]] = m_run[k];
          m_ord[k][m_n[k]] = m_wb[k];
          m_n[k]++;
          m_cnt[k] = (m_cnt[k] + 1) & 32'hFFFF;
          m_ptr[k] = 0;
          if (!cont) m_st[k] = M_IDLE;
          else if (!mfull(k, !m_wb[k])) m_wb[k] = !m_wb[k];
          else m_st[k] = M_WAIT;
        end
      end
      M_WAIT: if (!f_ow) begin
        m_wb[k] = !m_wb[k];
        m_st[k] = M_FILL;
      end
      default: m_st[k] = M_IDLE;
    endcase
  endtask

  task automatic check_all(input int k);
    chk($sformatf("u%0d_in_ready", k), o_rdy[k], m_st[k] == M_FILL);
    chk($sformatf("u%0d_win_valid", k), o_wv[k], m_n[k] > 0);
    chk($sformatf("u%0d_win_count", k), o_cnt[k], m_cnt[k]);
    chk($sformatf("u%0d_busy", k), o_busy[k],
        m_st[k] != M_IDLE || m_n[k] > 0);
    chk($sformatf("u%0d_rd_data", k), o_rd[k], m_rd[k]);
    if (m_n[k] > 0) begin
      chk($sformatf("u%0d_win_bank", k), o_bank[k], m_ord[k][0]);
      chk($sformatf("u%0d_win_max", k), o_max[k],
          m_mx[k][m_ord[k][0]]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_step(0);
    m_step(1);
    #1;
    check_all(0);
    check_all(1);
  endtask

  task automatic drive(input logic st, input logic vl,
                       input logic [DW-1:0] d,
                       input logic [AW-1:0] a,
                       input logic dn);
    for (int k = 0; k < 2; k++) begin
      s_start[k] = st;
      s_valid[k] = vl;
      s_data[k]  = d;
      s_addr[k]  = a;
      s_done[k]  = dn;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_in_ready", o_rdy[k], 0);
      chk("rst_win_valid", o_wv[k], 0);
      chk("rst_win_bank", o_bank[k], 0);
      chk("rst_rd_data", o_rd[k], 0);
      chk("rst_win_max", o_max[k], 0);
      chk("rst_win_count", o_cnt[k], 0);
      chk("rst_busy", o_busy[k], 0);
    end
    m_reset();
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  logic [DW-1:0] t2 [WL] = '{8'd16, 8'd15, 8'd7, 8'd3, 8'd0, 8'd3,
                             8'd5, 8'd6, 8'd6, 8'd7, 8'd7, 8'd7,
                             8'd7, 8'd7, 8'd7, 8'd9};

  initial begin
    drive(0, 0, 0, 0, 0);
    m_reset();
    rst = 1'b1;
    #2;
    do_reset();

    // Reset mid-fill, then refill from index 0
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, DW'(100 + i), 0, 0); tick();
    end
    do_reset();
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < WL; i++) begin
      drive(0, 1, DW'(40 + i), 0, 0); tick();
    end
    drive(0, 0, 0, 0, 0); tick();
    chk("t1_first", o_rd[0], 40);
    chk("t1_count", o_cnt[0], 1);

    // Directed stream, single-shot
    do_reset();
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < WL; i++) begin
      drive(0, 1, t2[i], 0, 0); tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("t2_ready", o_rdy[0], 0);
    chk("t2_valid", o_wv[0], 1);
    chk("t2_max", o_max[0], 16);
    chk("t2_count", o_cnt[0], 1);
    for (int i = 0; i < WL; i++) begin
      drive(0, 0, 0, AW'(i), 0); tick();
      chk("t2_rd", o_rd[0], t2[i]);
    end
    drive(0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0); tick();

    // Continuous, reader stalls
    do_reset();
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 40; i++) begin
      drive(0, 1, DW'($urandom), 0, 0); tick();
    end
    drive(0, 0, 0, 0, 0);
    chk("t3_ready", o_rdy[1], 0);
    chk("t3_bank", o_bank[1], 0);
    chk("t3_count", o_cnt[1], 2);
    drive(0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0);
    chk("t3_bank_next", o_bank[1], 1);
    chk("t3_ready_hold", o_rdy[1], 0);
    tick();
    chk("t3_ready_back", o_rdy[1], 1);

    // Release and completion in the same cycle
    do_reset();
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 2 * WL - 1; i++) begin
      drive(0, 1, DW'($urandom), 0, 0); tick();
    end
    drive(0, 1, DW'($urandom), 0, 1); tick();
    drive(0, 0, 0, 0, 0);
    chk("t4_ready", o_rdy[1], 1);
    chk("t4_bank", o_bank[1], 1);
    chk("t4_count", o_cnt[1], 2);
    chk("t4_valid", o_wv[1], 1);

    // Gappy valid, all-ones then all-zeros windows
    do_reset();
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 2 * WL; i++) begin
      drive(0, (i % 2) == 0, 8'hFF, 0, 0); tick();
    end
    chk("t5_max_ff", o_max[0], 8'hFF);
    chk("t5_count1", o_cnt[0], 1);
    drive(0, 0, 0, 0, 1); tick();
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < 2 * WL; i++) begin
      drive(0, (i % 2) == 0, 8'h00, 0, 0); tick();
    end
    chk("t5_max_00", o_max[0], 8'h00);
    chk("t5_count2", o_cnt[0], 2);

    // Stray release and start while filling
    do_reset();
    drive(0, 0, 0, 0, 1); tick();
    chk("t6_busy", o_busy[0], 0);
    chk("t6_count0", o_cnt[0], 0);
    drive(1, 0, 0, 0, 0); tick();
    for (int i = 0; i < WL; i++) begin
      drive(i == 3, 1, DW'(i * 3), 0, 0); tick();
    end
    drive(0, 0, 0, 0, 0); tick();
    chk("t6_count1", o_cnt[0], 1);
    chk("t6_max", o_max[0], 45);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      for (int k = 0; k < 2; k++) begin
        s_start[k] = ($urandom % 16) == 0;
        s_valid[k] = ($urandom % 2) == 0;
        s_data[k]  = DW'($urandom);
        s_addr[k]  = AW'($urandom);
        s_done[k]  = ($urandom % 10) == 0;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
